// File: rtl/mux_arb_pkg.sv
// Shared definitions for the two-source round-robin mux arbiter.
// The state encoding doubles as the one-hot grant vector.
package mux_arb_pkg;

  localparam int HOLD_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    G0   = 2'd1,
    G1   = 2'd2
  } arb_state_e;

  function automatic arb_state_e grant_state(input logic src);
    return src ? G1 : G0;
  endfunction

endpackage

// File: rtl/mux2_dw.sv
// Parameterized DW-wide 2:1 multiplexer.
module mux2_dw #(
  parameter int DW = 8
) (
  input  logic          s,
  input  logic [DW-1:0] i0,
  input  logic [DW-1:0] i1,
  output logic [DW-1:0] y
);

  assign y = s ? i1 : i0;

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter for two sources sharing a 2:1 mux, with a bounded
// hold time while the other source is waiting. Grant and select are registered.
module mux_rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter int DW       = 8,
  parameter int MAX_HOLD = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [1:0]    req,
  input  logic [DW-1:0] i0,
  input  logic [DW-1:0] i1,
  output logic [1:0]    gnt,
  output logic          s,
  output logic [DW-1:0] y,
  output logic          y_valid
);

  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

  arb_state_e        state_q, state_d;
  logic              last_q, last_d;
  logic              s_q, s_d;
  logic [HOLD_W-1:0] hold_q, hold_d;

  logic grant_v;
  logic grant_src;
  logic own;

  always_comb begin
    // NOTE: every signal driven here gets a default first so no path can infer a latch.
    state_d   = state_q;
    last_d    = last_q;
    s_d       = s_q;
    hold_d    = hold_q;
    grant_v   = 1'b0;
    grant_src = 1'b0;
    own       = (state_q == G1);

    unique case (state_q)
      IDLE: begin
        if (req == 2'b11) begin
          grant_v   = 1'b1;
          grant_src = ~last_q;
        end else if (req[0] || req[1]) begin
          grant_v   = 1'b1;
          grant_src = req[1];
        end
      end
      G0, G1: begin
        if (!req[own]) begin
          if (req[~own]) begin
            grant_v   = 1'b1;
            grant_src = ~own;
          end else begin
            state_d = IDLE;
          end
        end else if (req[~own] && hold_q == HOLD_LAST) begin
          grant_v   = 1'b1;
          grant_src = ~own;
        end else if (hold_q != HOLD_LAST) begin
          hold_d = hold_q + HOLD_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // Every grant entry restarts the tenure and moves the select with it.
    if (grant_v) begin
      state_d = grant_state(grant_src);
      last_d  = grant_src;
      s_d     = grant_src;
      hold_d  = '0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      s_q     <= 1'b0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      s_q     <= s_d;
      hold_q  <= hold_d;
    end
  end

  // G0/G1 encodings are already the one-hot grant pattern.
  assign gnt     = state_q;
  assign s       = s_q;
  assign y_valid = (gnt[0] & req[0]) | (gnt[1] & req[1]);

  mux2_dw #(.DW(DW)) u_mux (
    .s  (s_q),
    .i0 (i0),
    .i1 (i1),
    .y  (y)
  );

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Self-checking bench for mux_rr_arbiter: directed scenarios plus random
// traffic compared against a tenure-based reference model.
module tb_mux_rr_arbiter;

  localparam int DW       = 8;
  localparam int MAX_HOLD = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [1:0]    req;
  logic [DW-1:0] i0, i1;
  logic [1:0]    gnt;
  logic          s;
  logic [DW-1:0] y;
  logic          y_valid;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: owner of the mux (-1 none), last winner, tenure length.
  int m_owner;
  int m_last;
  int m_tenure;
  int m_s;
  int wait_cnt[2];

  always #5 clk = ~clk;

  mux_rr_arbiter #(.DW(DW), .MAX_HOLD(MAX_HOLD)) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .i0      (i0),
    .i1      (i1),
    .gnt     (gnt),
    .s       (s),
    .y       (y),
    .y_valid (y_valid)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_owner     = -1;
    m_last      = 1;
    m_tenure    = 0;
    m_s         = 0;
    wait_cnt[0] = 0;
    wait_cnt[1] = 0;
  endtask

  task automatic model_grant(input int src);
    m_owner  = src;
    m_last   = src;
    m_tenure = 1;
    m_s      = src;
  endtask

  task automatic model_step(input logic [1:0] r);
    int want[2];
    int other;
    want[0] = int'(r[0]);
    want[1] = int'(r[1]);
    if (m_owner < 0) begin
      if (want[0] == 1 && want[1] == 1) model_grant(1 - m_last);
      else if (want[0] == 1)            model_grant(0);
      else if (want[1] == 1)            model_grant(1);
    end else begin
      other = 1 - m_owner;
      if (want[m_owner] == 0) begin
        if (want[other] == 1) model_grant(other);
        else m_owner = -1;
      end else if (want[other] == 1 && m_tenure >= MAX_HOLD) begin
        model_grant(other);
      end else begin
        m_tenure++;
      end
    end
  endtask

  function automatic logic [1:0] exp_gnt();
    return (m_owner == 0) ? 2'b01 : (m_owner == 1) ? 2'b10 : 2'b00;
  endfunction

  // Called at a falling edge; returns at the next falling edge.
  task automatic step(input logic [1:0] r, input logic [DW-1:0] d0, input logic [DW-1:0] d1);
    logic [1:0] g;
    req = r;
    i0  = d0;
    i1  = d1;
    #1;
    g = exp_gnt();
    check("y_valid_comb", y_valid, (g[0] & r[0]) | (g[1] & r[1]));
    check("y_comb", y, (m_s == 1) ? d1 : d0);
    @(posedge clk);
    model_step(r);
    @(negedge clk);
    g = exp_gnt();
    check("gnt", gnt, g);
    check("s", s, m_s[0]);
    check("y", y, (m_s == 1) ? d1 : d0);
    check("y_valid", y_valid, (g[0] & r[0]) | (g[1] & r[1]));
    check("gnt_legal", gnt != 2'b11, 1'b1);
    for (int k = 0; k < 2; k++) begin
      if (r[k] && !gnt[k]) wait_cnt[k]++;
      else wait_cnt[k] = 0;
      check("wait_bound", wait_cnt[k] <= MAX_HOLD + 1, 1'b1);
    end
  endtask

  task automatic rnd_step(input logic [1:0] r);
    step(r, DW'($urandom), DW'($urandom));
  endtask

  // Called at a falling edge; pulses reset between clock edges.
  task automatic pulse_reset();
    req = 2'b00;
    #2 rst = 1'b1;
    #1;
    check("rst_gnt", gnt, 2'b00);
    check("rst_s", s, 1'b0);
    check("rst_y_valid", y_valid, 1'b0);
    check("rst_y", y, i0);
    #1 rst = 1'b0;
    model_reset();
    @(negedge clk);
  endtask

  initial begin
    model_reset();
    rst = 1'b1;
    req = 2'b11;
    i0  = 8'h3C;
    i1  = 8'hC3;

    // 1. Reset with both requesting, before any clock edge.
    #2;
    check("t1_gnt", gnt, 2'b00);
    check("t1_s", s, 1'b0);
    check("t1_y_valid", y_valid, 1'b0);
    check("t1_y", y, 8'h3C);
    @(negedge clk);
    rst = 1'b0;
    rnd_step(2'b11);
    check("t1_first_grant", gnt, 2'b01);

    // 2. Single requester 1.
    pulse_reset();
    step(2'b10, 8'h11, 8'hA5);
    check("t2_gnt", gnt, 2'b10);
    check("t2_s", s, 1'b1);
    check("t2_y", y, 8'hA5);
    check("t2_y_valid", y_valid, 1'b1);
    step(2'b00, 8'h11, 8'hA5);
    check("t2_idle_gnt", gnt, 2'b00);
    check("t2_idle_s", s, 1'b1);

    // 3. Tie break and handover.
    pulse_reset();
    rnd_step(2'b11);
    check("t3_tie", gnt, 2'b01);
    rnd_step(2'b10);
    check("t3_handover", gnt, 2'b10);
    rnd_step(2'b00);
    check("t3_idle", gnt, 2'b00);
    rnd_step(2'b11);
    check("t3_tie_last", gnt, 2'b01);

    // 4. Continuous contention rotates every MAX_HOLD cycles.
    pulse_reset();
    for (int k = 0; k < 24; k++) begin
      rnd_step(2'b11);
      check("t4_rotation", gnt, ((k / MAX_HOLD) % 2 == 0) ? 2'b01 : 2'b10);
    end

    // 5. No preemption without contention, then immediate rotation.
    pulse_reset();
    for (int k = 0; k < 20; k++) begin
      rnd_step(2'b01);
      check("t5_hold", gnt, 2'b01);
    end
    rnd_step(2'b11);
    check("t5_rotate", gnt, 2'b10);

    // 6. Reset in the middle of a G1 tenure.
    pulse_reset();
    rnd_step(2'b10);
    rnd_step(2'b10);
    rnd_step(2'b10);
    check("t6_in_g1", gnt, 2'b10);
    pulse_reset();
    rnd_step(2'b11);
    check("t6_after_rst", gnt, 2'b01);

    // Random traffic, biased towards contention, with occasional resets.
    for (int k = 0; k < 600; k++) begin
      if ($urandom_range(0, 49) == 0) pulse_reset();
      else if ($urandom_range(0, 2) == 0) rnd_step(2'b11);
      else rnd_step(2'($urandom_range(0, 3)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
